// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Arbitrates the I-cache and D-cache line requests onto a single L2 port with
// at most one L2 transaction in flight. D-cache requests win ties. When the
// macro ARB_STARVE_GUARD_EN is defined, a 4-bit starvation counter forces an
// I grant after STARVE_LIMIT consecutive D grants taken while I was waiting.
// With the macro undefined, ties always go to D.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   i_read, i_address        I-cache line read request
//   i_resp, i_rdata          I-cache completion and returned line
//   d_read, d_write          D-cache line read / write-back request
//   d_address, d_wdata       D-cache address and write-back line
//   d_resp, d_rdata          D-cache completion and returned line
//   l2_read, l2_write        L2 command, driven from latched registers
//   l2_address, l2_wdata     L2 address / write data, driven from latched registers
//   l2_resp, l2_rdata        L2 completion and read line
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_read,
    input  logic [15:0]   i_address,
    output logic          i_resp,
    output logic [127:0]  i_rdata,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [15:0]   d_address,
    input  logic [127:0]  d_wdata,
    output logic          d_resp,
    output logic [127:0]  d_rdata,
    output logic          l2_read,
    output logic          l2_write,
    output logic [15:0]   l2_address,
    output logic [127:0]  l2_wdata,
    input  logic          l2_resp,
    input  logic [127:0]  l2_rdata
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    // Reject out-of-range limits at elaboration.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("cache_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                d_req_c;
    logic                starved_c;

    assign d_req_c = d_read | d_write;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign starved_c = (cnt_q == CNT_W'(STARVE_LIMIT));

    // Count D grants taken over a waiting I; any other grant clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (d_req_c && !(i_read && starved_c)) begin
                if (!i_read) begin
                    cnt_d = '0;
                end else if (!starved_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (i_read) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign starved_c = 1'b0;
`endif

    // Next-state, grant latching and completion strobes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        i_resp  = 1'b0;
        d_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req_c && !(i_read && starved_c)) begin
                    state_d = GRANT_D;
                    addr_d  = d_address;
                    // Read and write together is treated as a write-back.
                    wr_d    = d_write;
                    rd_d    = ~d_write;
                    wdata_d = d_write ? d_wdata : '0;
                end else if (i_read) begin
                    state_d = GRANT_I;
                    addr_d  = i_address;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            GRANT_I: begin
                if (l2_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            GRANT_D: begin
                if (l2_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign l2_read    = rd_q;
    assign l2_write   = wr_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    // Both caches see the L2 line; the resp strobes say whose it is.
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
// Table-driven single-request vectors plus hand sequences for bubble,
// starvation and reset-during-grant. Expected L2 transactions are pushed to a
// scoreboard queue when requests are driven and popped when the L2 model
// sees the command.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int unsigned LIMIT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [15:0]   i_address;
    logic          i_resp;
    logic [127:0]  i_rdata;
    logic          d_read;
    logic          d_write;
    logic [15:0]   d_address;
    logic [127:0]  d_wdata;
    logic          d_resp;
    logic [127:0]  d_rdata;
    logic          l2_read;
    logic          l2_write;
    logic [15:0]   l2_address;
    logic [127:0]  l2_wdata;
    logic          l2_resp;
    logic [127:0]  l2_rdata;

    always #5 clk = ~clk;

    cache_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_resp     (i_resp),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_resp     (d_resp),
        .d_rdata    (d_rdata),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_resp    (l2_resp),
        .l2_rdata   (l2_rdata)
    );

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [15:0]   addr;
        logic [127:0]  wdata;
    } txn_t;

    typedef struct {
        logic          i_rd;
        logic [15:0]   i_addr;
        logic          d_rd;
        logic          d_wr;
        logic [15:0]   d_addr;
        logic [127:0]  d_wd;
        int            lat;
        logic [127:0]  rdata;
        logic          exp_d;
        logic          exp_wr;
    } vec_t;

    txn_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic wr, input logic [15:0] addr,
                            input logic [127:0] wdata);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = addr;
        t.wdata = wdata;
        sb_q.push_back(t);
    endtask

    task automatic idle_reqs();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // L2 model: called at posedge+1; waits for a command, checks it against
    // the scoreboard, holds it lat cycles, responds in cycle lat, returns at
    // posedge+1 of the cycle after the response.
    task automatic serve(input int lat, input logic [127:0] rdata, input bit mut,
                         output int waited);
        txn_t e;
        waited = 0;
        #1;
        while (!(l2_read || l2_write) && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!(l2_read || l2_write)) begin
            check("cmd_timeout", 128'(1'b0), 128'(1'b1));
            return;
        end
        if (sb_q.size() == 0) begin
            check("sb_underflow", 128'(1'b0), 128'(1'b1));
            return;
        end
        e = sb_q.pop_front();
        check("l2_write", 128'(l2_write), 128'(e.wr));
        check("l2_read", 128'(l2_read), 128'(!e.wr));
        check("l2_address", 128'(l2_address), 128'(e.addr));
        if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
                if (mut && c == 2) begin
                    d_address = 16'hFFFF;
                    i_address = 16'hFFFF;
                    d_wdata   = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (c == lat) begin
                l2_rdata = rdata;
                l2_resp  = 1'b1;
            end
            #1;
            check("hold_addr", 128'(l2_address), 128'(e.addr));
            check("hold_op", 128'({l2_read, l2_write}), 128'({!e.wr, e.wr}));
            if (e.wr) check("hold_wdata", l2_wdata, e.wdata);
            if (c == lat) begin
                check("i_resp", 128'(i_resp), 128'(!e.is_d));
                check("d_resp", 128'(d_resp), 128'(e.is_d));
                check("i_rdata", i_rdata, rdata);
                check("d_rdata", d_rdata, rdata);
            end else begin
                check("early_resp", 128'({i_resp, d_resp}), 128'(2'b00));
            end
        end
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int          w;
        int unsigned cnt_m;
        logic        d_g;

        vecs[0] = '{1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, 128'h0, 5, {16{8'hA5}}, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h2222, 128'h0, 2, {4{32'hDEADBEEF}}, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h4000, {2{64'h0123456789ABCDEF}}, 3,
                    128'h0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0800, {8{16'h5A5A}}, 2, 128'h0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h3333, 128'h0, 1, {4{32'h13579BDF}}, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 128'h0, 1, {4{32'h02468ACE}}, 1'b0, 1'b0};

        reset     = 1'b1;
        idle_reqs();
        i_address = '0;
        d_address = '0;
        d_wdata   = '0;
        l2_resp   = 1'b0;
        l2_rdata  = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_l2_cmd", 128'({l2_read, l2_write}), 128'(2'b00));
        check("rst_l2_address", 128'(l2_address), 128'(16'h0));
        check("rst_l2_wdata", l2_wdata, 128'h0);
        check("rst_resp", 128'({i_resp, d_resp}), 128'(2'b00));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table of single requests from IDLE
        for (int k = 0; k < 6; k++) begin
            i_read    = vecs[k].i_rd;
            i_address = vecs[k].i_addr;
            d_read    = vecs[k].d_rd;
            d_write   = vecs[k].d_wr;
            d_address = vecs[k].d_addr;
            d_wdata   = vecs[k].d_wd;
            push_exp(vecs[k].exp_d, vecs[k].exp_wr,
                     vecs[k].exp_d ? vecs[k].d_addr : vecs[k].i_addr, vecs[k].d_wd);
            @(posedge clk);
            #1;
            idle_reqs();
            serve(vecs[k].lat, vecs[k].rdata, 1'b1, w);
            check("grant_latency", 128'(w), 128'(0));
        end

        // Combined read+write from D with a queued I read: one bubble between
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 16'h0800;
        d_wdata   = {4{32'hCAFEF00D}};
        i_read    = 1'b1;
        i_address = 16'h0A0A;
        push_exp(1'b1, 1'b1, 16'h0800, {4{32'hCAFEF00D}});
        push_exp(1'b0, 1'b0, 16'h0A0A, 128'h0);
        @(posedge clk);
        #1;
        d_read  = 1'b0;
        d_write = 1'b0;
        serve(2, 128'h0, 1'b0, w);
        #1;
        check("bubble_idle", 128'({l2_read, l2_write}), 128'(2'b00));
        @(posedge clk);
        #1;
        i_read = 1'b0;
        serve(1, {4{32'h11223344}}, 1'b0, w);
        check("after_bubble", 128'(w), 128'(0));

        // Reset pulsed during GRANT_D with a response arriving during and after it
        d_write   = 1'b1;
        d_address = 16'h5555;
        d_wdata   = {4{32'h89ABCDEF}};
        @(posedge clk);
        #1;
        idle_reqs();
        #1;
        check("pre_rst_write", 128'(l2_write), 128'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_cmd", 128'({l2_read, l2_write}), 128'(2'b00));
        check("async_rst_addr", 128'(l2_address), 128'(16'h0));
        check("async_rst_wdata", l2_wdata, 128'h0);
        l2_resp  = 1'b1;
        l2_rdata = {4{32'h77777777}};
        #1;
        check("rst_resp_ignored", 128'({i_resp, d_resp}), 128'(2'b00));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_resp_ignored", 128'({i_resp, d_resp}), 128'(2'b00));
        check("post_rst_cmd", 128'({l2_read, l2_write}), 128'(2'b00));
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
        // FSM must be IDLE: a lone I read gets the normal one-edge latency
        i_read    = 1'b1;
        i_address = 16'h0C0C;
        push_exp(1'b0, 1'b0, 16'h0C0C, 128'h0);
        @(posedge clk);
        #1;
        idle_reqs();
        serve(1, {4{32'h0BADCAFE}}, 1'b0, w);
        check("post_rst_latency", 128'(w), 128'(0));

        // Both requesters held continuously
        i_read    = 1'b1;
        i_address = 16'h1AAA;
        d_read    = 1'b1;
        d_address = 16'h2DDD;
        cnt_m     = 0;
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            d_g = (cnt_m != LIMIT);
`else
            d_g = 1'b1;
`endif
            if (d_g) begin
                push_exp(1'b1, 1'b0, 16'h2DDD, 128'h0);
                if (cnt_m < LIMIT) cnt_m++;
            end else begin
                push_exp(1'b0, 1'b0, 16'h1AAA, 128'h0);
                cnt_m = 0;
            end
        end
        for (int k = 0; k < 8; k++) begin
            serve(1, {4{$urandom}}, 1'b0, w);
            check("held_bubble", 128'(w), 128'(1));
        end
        idle_reqs();
        @(posedge clk);
        #2;
        check("final_idle", 128'({l2_read, l2_write}), 128'(2'b00));
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
